// File: rtl/dvp_capture_pkg.sv
// Shared types for the DVP capture path: FSM encoding, default counter widths, word layout.
package dvp_capture_pkg;

   localparam int PIX_W_DEF  = 12;
   localparam int LINE_W_DEF = 11;
   localparam int WORD_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_WAIT_FS,
      ST_CAPTURE
   } cap_state_t;

   typedef struct packed {
      logic [15:0] pix1;
      logic [15:0] pix0;
   } word_t;

   // First byte on the wire is the high half of the RGB565 pixel.
   function automatic logic [15:0] rgb565(input logic [7:0] byte0, input logic [7:0] byte1);
      return {byte0, byte1};
   endfunction

endpackage

// File: rtl/dvp_pixel_packer_if.sv
// Packed-pixel word stream from the DVP packer towards the SDRAM write FIFO.
interface dvp_pixel_packer_if;
   import dvp_capture_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_sof;
   logic              out_eol;

   modport master (output out_valid, out_data, out_sof, out_eol, input out_ready);
   modport slave  (input out_valid, out_data, out_sof, out_eol, output out_ready);
endinterface

// File: rtl/dvp_byte_pair.sv
// DVP pin register (S0) plus byte-phase assembly into RGB565 pixel strobes.
// Latency: pixel_valid is combinational from S0, one edge after the second byte is on the pins.
// Backpressure: none; pixels are produced at the camera rate and must be consumed.
module dvp_byte_pair
   import dvp_capture_pkg::*;
#(
   parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  dvp_data,
   input  logic        dvp_href,
   input  logic        dvp_vsync,
   input  logic        assemble,
   input  logic        clear,
   output logic        vs_act,
   output logic        href_fall,
   output logic        pixel_valid,
   output logic [15:0] pixel
);
   logic [7:0] s0_data;
   logic [7:0] byte0_q;
   logic       s0_href;
   logic       s0_vsync;
   logic       href_prev;
   logic       phase_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_data   <= '0;
         s0_href   <= 1'b0;
         s0_vsync  <= 1'b0;
         href_prev <= 1'b0;
         phase_q   <= 1'b0;
         byte0_q   <= '0;
      end else begin
         s0_data   <= dvp_data;
         s0_href   <= dvp_href;
         s0_vsync  <= dvp_vsync;
         href_prev <= s0_href;
         // Dropping href discards an odd trailing byte by resetting the phase.
         if (clear || !assemble || !s0_href) begin
            phase_q <= 1'b0;
         end else begin
            phase_q <= !phase_q;
            if (!phase_q) byte0_q <= s0_data;
         end
      end
   end

   assign vs_act      = VSYNC_ACTIVE_HIGH ? s0_vsync : !s0_vsync;
   assign href_fall   = href_prev && !s0_href;
   assign pixel_valid = assemble && s0_href && phase_q && !clear;
   assign pixel       = rgb565(byte0_q, s0_data);

endmodule

// File: rtl/dvp_pixel_packer.sv
// One-frame DVP capture: RGB565 pixels packed two per word, sof/eol marked, line stats reported.
// Latency: a word is valid 2 edges after its 4th byte is sampled into S0's input (1 edge after S0).
// Backpressure: single output register; a word arriving while it is full and not draining is dropped, overflow set.
module dvp_pixel_packer
   import dvp_capture_pkg::*;
#(
   parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
   parameter int PIX_W             = PIX_W_DEF,
   parameter int LINE_W            = LINE_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                dvp_data,
   input  logic                      dvp_href,
   input  logic                      dvp_vsync,
   input  logic                      start,
   input  logic                      abort,
   dvp_pixel_packer_if.master        pix,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [LINE_W-1:0]         line_count,
   output logic [PIX_W-1:0]          line_pixels
);
   cap_state_t       state_q, state_d;
   logic             vs_act, href_fall, pixel_valid;
   logic [15:0]      pixel;
   logic             capture;
   logic             arm, enter_capture, frame_end;
   logic             slot_q;
   logic [15:0]      pix0_q;
   logic [PIX_W-1:0] pix_cnt_q;
   logic             sof_pending_q;
   logic             word_fire, word_eol, load_ok;
   word_t            word_dat;

   assign capture = (state_q == ST_CAPTURE);
   assign busy    = (state_q != ST_IDLE);
   assign load_ok = !pix.out_valid || pix.out_ready;

   dvp_byte_pair #(.VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)) u_byte_pair (
      .clk         (clk),
      .reset       (reset),
      .dvp_data    (dvp_data),
      .dvp_href    (dvp_href),
      .dvp_vsync   (dvp_vsync),
      .assemble    (capture),
      .clear       (abort),
      .vs_act      (vs_act),
      .href_fall   (href_fall),
      .pixel_valid (pixel_valid),
      .pixel       (pixel)
   );

   always_comb begin
      state_d       = state_q;
      arm           = 1'b0;
      enter_capture = 1'b0;
      frame_end     = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (start)   begin state_d = ST_WAIT_VS; arm = 1'b1; end
            ST_WAIT_VS: if (vs_act)  state_d = ST_WAIT_FS;
            ST_WAIT_FS: if (!vs_act) begin state_d = ST_CAPTURE; enter_capture = 1'b1; end
            ST_CAPTURE: if (vs_act)  begin state_d = ST_IDLE; frame_end = 1'b1; end
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // The raw href pin is one sample ahead of S0, so it tells us whether a
   // word completing now is the last full word of the line.
   always_comb begin
      word_fire = 1'b0;
      word_eol  = 1'b0;
      word_dat  = '0;
      if (capture && !abort && slot_q) begin
         if (pixel_valid) begin
            word_fire     = 1'b1;
            word_dat.pix1 = pixel;
            word_dat.pix0 = pix0_q;
            word_eol      = !dvp_href;
         end else if (href_fall) begin
            word_fire     = 1'b1;
            word_dat.pix1 = 16'h0000;
            word_dat.pix0 = pix0_q;
            word_eol      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pix.out_valid <= 1'b0;
         pix.out_data  <= '0;
         pix.out_sof   <= 1'b0;
         pix.out_eol   <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         line_count    <= '0;
         line_pixels   <= '0;
         slot_q        <= 1'b0;
         pix0_q        <= '0;
         pix_cnt_q     <= '0;
         sof_pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (abort) begin
            pix.out_valid <= 1'b0;
            slot_q        <= 1'b0;
            pix_cnt_q     <= '0;
            sof_pending_q <= 1'b0;
         end else begin
            if (pix.out_valid && pix.out_ready) pix.out_valid <= 1'b0;
            if (word_fire) begin
               sof_pending_q <= 1'b0;
               if (load_ok) begin
                  pix.out_valid <= 1'b1;
                  pix.out_data  <= word_dat;
                  pix.out_sof   <= sof_pending_q;
                  pix.out_eol   <= word_eol;
               end else begin
                  overflow <= 1'b1;
               end
            end
            if (capture && pixel_valid) begin
               slot_q <= !slot_q;
               if (!slot_q) pix0_q <= pixel;
               if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            end else if (!capture || href_fall) begin
               slot_q    <= 1'b0;
               pix_cnt_q <= '0;
            end
            if (capture && href_fall) begin
               line_pixels <= pix_cnt_q;
               if (line_count != '1) line_count <= line_count + LINE_W'(1);
            end
            if (arm) begin
               done       <= 1'b0;
               overflow   <= 1'b0;
               line_count <= '0;
            end
            if (enter_capture) sof_pending_q <= 1'b1;
            if (frame_end) done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Directed bench for dvp_pixel_packer: framing, packing, line end, backpressure, abort, reset.
module tb_dvp_pixel_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  dvp_data;
   logic        dvp_href;
   logic        dvp_vsync;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [10:0] line_count;
   logic [11:0] line_pixels;

   int checks   = 0;
   int failures = 0;

   dvp_pixel_packer_if bus();

   dvp_pixel_packer #(.VSYNC_ACTIVE_HIGH(1'b1), .PIX_W(12), .LINE_W(11)) dut (
      .clk         (clk),
      .reset       (reset),
      .dvp_data    (dvp_data),
      .dvp_href    (dvp_href),
      .dvp_vsync   (dvp_vsync),
      .start       (start),
      .abort       (abort),
      .pix         (bus),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .line_count  (line_count),
      .line_pixels (line_pixels)
   );

   always #5 clk = ~clk;

   // Word log: transfers seen at the negedge before the edge that accepts them.
   int          wcnt = 0;
   logic [31:0] w_dat [0:4095];
   logic        w_sof [0:4095];
   logic        w_eol [0:4095];

   always @(negedge clk) begin
      if (!reset && !abort && bus.out_valid && bus.out_ready) begin
         if (wcnt < 4096) begin
            w_dat[wcnt] = bus.out_data;
            w_sof[wcnt] = bus.out_sof;
            w_eol[wcnt] = bus.out_eol;
         end
         wcnt = wcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic begin_frame();
      dvp_vsync = 1'b0;
      dvp_href  = 1'b0;
      tick(2);
      start = 1'b1;
      tick(1);
      start     = 1'b0;
      dvp_vsync = 1'b1;
      tick(3);
      dvp_vsync = 1'b0;
      tick(3);
   endtask

   task automatic end_frame();
      dvp_href  = 1'b0;
      dvp_vsync = 1'b1;
      tick(4);
   endtask

   // mode 0: ready high; 1: ready only every 4th edge; 2: ready low for 8 edges mid-line
   task automatic send_line(input int n, input int base, input int step, input int mode);
      for (int i = 0; i < n + 12; i++) begin
         if (i < n) begin
            dvp_href = 1'b1;
            dvp_data = 8'(base + i * step);
         end else begin
            dvp_href = 1'b0;
            dvp_data = 8'h00;
         end
         case (mode)
            1:       bus.out_ready = (i % 4 == 0);
            2:       bus.out_ready = !(i >= 46 && i <= 53);
            default: bus.out_ready = 1'b1;
         endcase
         tick(1);
      end
      bus.out_ready = 1'b1;
   endtask

   function automatic int count_flags(input int a, input int b, input bit use_sof);
      int n = 0;
      for (int k = a; k < b; k++) n += use_sof ? int'(w_sof[k]) : int'(w_eol[k]);
      return n;
   endfunction

   initial begin
      int w0;
      reset         = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      dvp_data      = 8'h00;
      dvp_href      = 1'b0;
      dvp_vsync     = 1'b0;
      bus.out_ready = 1'b1;
      tick(3);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_sof", bus.out_sof, 0);
      chk("rst_eol", bus.out_eol, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_lines", line_count, 0);
      chk("rst_lpix", line_pixels, 0);
      reset = 1'b0;
      tick(2);

      // Three 640-byte lines
      begin_frame();
      chk("vga_busy", busy, 1);
      w0 = wcnt;
      for (int l = 0; l < 3; l++) send_line(640, 0, 1, 0);
      end_frame();
      chk("vga_words", wcnt - w0, 480);
      chk("vga_first", w_dat[w0], 32'h0203_0001);
      chk("vga_sof_first", w_sof[w0], 1);
      chk("vga_sof_count", count_flags(w0, w0 + 480, 1'b1), 1);
      chk("vga_eol_count", count_flags(w0, w0 + 480, 1'b0), 3);
      chk("vga_eol_pos", {w_eol[w0 + 159], w_eol[w0 + 319], w_eol[w0 + 479]}, 3'b111);
      chk("vga_last_word", w_dat[w0 + 159], 32'h7E7F_7C7D);
      chk("vga_lines", line_count, 3);
      chk("vga_lpix", line_pixels, 320);
      chk("vga_done", done, 1);
      chk("vga_idle", busy, 0);
      chk("vga_ovf", overflow, 0);

      // 12 34 56 78 with latency and hold under backpressure
      begin_frame();
      chk("start_clr_done", done, 0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dvp_href = 1'b1;
         dvp_data = 8'(8'h12 + i * 8'h22);
         tick(1);
      end
      chk("lat_not_yet", bus.out_valid, 0);
      dvp_href = 1'b0;
      tick(1);
      chk("lat_valid", bus.out_valid, 1);
      chk("lat_data", bus.out_data, 32'h5678_1234);
      chk("lat_eol", bus.out_eol, 1);
      chk("lat_sof", bus.out_sof, 1);
      tick(1);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 32'h5678_1234);
      bus.out_ready = 1'b1;
      tick(8);
      end_frame();
      chk("short_lpix", line_pixels, 2);

      // Odd 7-byte line
      begin_frame();
      w0 = wcnt;
      send_line(7, 'hA1, 1, 0);
      end_frame();
      chk("odd_words", wcnt - w0, 2);
      chk("odd_w0", w_dat[w0], 32'hA3A4_A1A2);
      chk("odd_w0_eol", w_eol[w0], 0);
      chk("odd_w1", w_dat[w0 + 1], 32'h0000_A5A6);
      chk("odd_w1_eol", w_eol[w0 + 1], 1);
      chk("odd_lpix", line_pixels, 3);

      // Ready low 3 of every 4 edges: lossless
      begin_frame();
      w0 = wcnt;
      send_line(640, 0, 1, 1);
      end_frame();
      chk("bp3_words", wcnt - w0, 160);
      chk("bp3_ovf", overflow, 0);

      // Ready low 8 edges: exactly one word lost
      begin_frame();
      w0 = wcnt;
      send_line(640, 0, 1, 2);
      end_frame();
      chk("bp8_words", wcnt - w0, 159);
      chk("bp8_ovf", overflow, 1);
      chk("bp8_last_eol", w_eol[w0 + 158], 1);

      // Start while the camera is mid-frame: wait for the next frame
      dvp_vsync = 1'b0;
      tick(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("mid_busy", busy, 1);
      chk("mid_ovf_clr", overflow, 0);
      w0 = wcnt;
      send_line(8, 1, 1, 0);
      chk("mid_no_words", wcnt - w0, 0);
      dvp_vsync = 1'b1;
      tick(3);
      dvp_vsync = 1'b0;
      tick(3);
      send_line(8, 1, 1, 0);
      end_frame();
      chk("mid_words", wcnt - w0, 2);
      chk("mid_data", w_dat[w0], 32'h0304_0102);

      // Abort mid-line with a word waiting
      begin_frame();
      w0 = wcnt;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dvp_href = 1'b1;
         dvp_data = 8'(8'h40 + i);
         tick(1);
      end
      chk("abt_pre_valid", bus.out_valid, 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abt_busy", busy, 0);
      chk("abt_valid", bus.out_valid, 0);
      chk("abt_done", done, 0);
      bus.out_ready = 1'b1;
      tick(4);
      end_frame();
      chk("abt_done_after", done, 0);
      chk("abt_words", wcnt - w0, 0);

      // Reset mid-line after one completed line
      begin_frame();
      send_line(8, 1, 1, 0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dvp_href = 1'b1;
         dvp_data = 8'(8'h11 + i);
         tick(1);
      end
      chk("rst2_pre_valid", bus.out_valid, 1);
      chk("rst2_pre_lines", line_count, 1);
      reset = 1'b1;
      tick(1);
      chk("rst2_valid", bus.out_valid, 0);
      chk("rst2_data", bus.out_data, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_lines", line_count, 0);
      chk("rst2_lpix", line_pixels, 0);
      chk("rst2_done", done, 0);
      reset         = 1'b0;
      dvp_href      = 1'b0;
      bus.out_ready = 1'b1;
      tick(2);
      begin_frame();
      w0 = wcnt;
      send_line(8, 1, 1, 0);
      end_frame();
      chk("clean_words", wcnt - w0, 2);
      chk("clean_w0", w_dat[w0], 32'h0304_0102);
      chk("clean_w1", w_dat[w0 + 1], 32'h0708_0506);
      chk("clean_sof", w_sof[w0], 1);
      chk("clean_eol", w_eol[w0 + 1], 1);
      chk("clean_lines", line_count, 1);
      chk("clean_done", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no summary, expected one");
      $fatal(1, "time limit");
   end

endmodule
